writeback_stage: RTL and testbench

- Final pipeline stage; consumes the control word produced by the upstream control pipeline register.
- Control word fields: memory-read flag, two write enables, 3-bit buffer select, 4-bit destination register.
- Selects the writeback source, performs multi-cycle memory reads with a request/valid handshake and stalls upstream while waiting.
- Drives both register-file write ports.

---
 rtl/writeback_stage.sv | 141 ++++++++++++++
 tb/tb_writeback_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: picks the port A source, writes both register-file ports, runs blocking memory reads.
// Results appear 1 cycle after accept or after mem_rd_valid; stall holds upstream while a read is outstanding.
module writeback_stage #(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              mem_read_in,
    input  logic              reg_wr_en_1_in,
    input  logic              reg_wr_en_2_in,
    input  logic [2:0]        buff_ctrl_in,
    input  logic [3:0]        reg_wr_sel_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_result_hi,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [DATA_W-1:0] pc_plus1,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              err_clr,
    output logic              stall,
    output logic              mem_rd_req,
    output logic              rf_wr_en_a,
    output logic [3:0]        rf_wr_addr_a,
    output logic [DATA_W-1:0] rf_wr_data_a,
    output logic              rf_wr_en_b,
    output logic [3:0]        rf_wr_addr_b,
    output logic [DATA_W-1:0] rf_wr_data_b,
    output logic              mem_err,
    output logic              ctrl_err,
    output logic [15:0]       retire_count
);
    typedef enum logic {RUN, WAIT_MEM} state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state;
    logic [7:0]          cnt;
    logic                lat_en_1;
    logic                lat_en_2;
    logic [3:0]          lat_sel;
    logic [DATA_W-1:0]   lat_hi;

    logic                accept;
    logic                is_mem;
    logic                rsv;
    logic                mem_set;
    logic                ctrl_set;
    logic [DATA_W-1:0]   src_data;

    // buff_ctrl 1 is the MEM source, so it takes the read path even without mem_read_in
    assign accept   = in_valid && !stall && (state == RUN);
    assign is_mem   = mem_read_in || (buff_ctrl_in == 3'd1);
    assign rsv      = (buff_ctrl_in >= 3'd5);
    assign ctrl_set = accept && !is_mem && rsv;
    assign mem_set  = (state == WAIT_MEM) && !mem_rd_valid && (cnt == TO_LAST);

    always_comb begin
        src_data = alu_result;
        case (buff_ctrl_in)
            3'd2:    src_data = imm_data;
            3'd3:    src_data = pc_plus1;
            3'd4:    src_data = alu_result_hi;
            default: src_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            cnt          <= '0;
            lat_en_1     <= 1'b0;
            lat_en_2     <= 1'b0;
            lat_sel      <= '0;
            lat_hi       <= '0;
            stall        <= 1'b0;
            mem_rd_req   <= 1'b0;
            rf_wr_en_a   <= 1'b0;
            rf_wr_addr_a <= '0;
            rf_wr_data_a <= '0;
            rf_wr_en_b   <= 1'b0;
            rf_wr_addr_b <= '0;
            rf_wr_data_b <= '0;
            mem_err      <= 1'b0;
            ctrl_err     <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_wr_en_a <= 1'b0;
            rf_wr_en_b <= 1'b0;
            // A set event in the same cycle overrides the clear
            mem_err    <= mem_set  || (mem_err  && !err_clr);
            ctrl_err   <= ctrl_set || (ctrl_err && !err_clr);
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_mem) begin
                            lat_en_1   <= reg_wr_en_1_in;
                            lat_en_2   <= reg_wr_en_2_in;
                            lat_sel    <= reg_wr_sel_in;
                            lat_hi     <= alu_result_hi;
                            cnt        <= '0;
                            stall      <= 1'b1;
                            mem_rd_req <= 1'b1;
                            state      <= WAIT_MEM;
                        end else begin
                            rf_wr_en_a   <= reg_wr_en_1_in && !rsv;
                            rf_wr_en_b   <= reg_wr_en_2_in && !rsv;
                            rf_wr_addr_a <= reg_wr_sel_in;
                            rf_wr_data_a <= src_data;
                            rf_wr_addr_b <= reg_wr_sel_in ^ 4'd1;
                            rf_wr_data_b <= alu_result_hi;
                            retire_count <= retire_count + 16'd1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rd_valid) begin
                        rf_wr_en_a   <= lat_en_1;
                        rf_wr_en_b   <= lat_en_2;
                        rf_wr_addr_a <= lat_sel;
                        rf_wr_data_a <= mem_rd_data;
                        rf_wr_addr_b <= lat_sel ^ 4'd1;
                        rf_wr_data_b <= lat_hi;
                        retire_count <= retire_count + 16'd1;
                        stall        <= 1'b0;
                        mem_rd_req   <= 1'b0;
                        state        <= RUN;
                    end else if (cnt == TO_LAST) begin
                        stall        <= 1'b0;
                        mem_rd_req   <= 1'b0;
                        state        <= RUN;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage against a transaction-level reference model.
module tb_writeback_stage;
    localparam int DATA_W      = 16;
    localparam int MEM_TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, mem_read_in, reg_wr_en_1_in, reg_wr_en_2_in;
    logic [2:0]        buff_ctrl_in;
    logic [3:0]        reg_wr_sel_in;
    logic [DATA_W-1:0] alu_result, alu_result_hi, imm_data, pc_plus1, mem_rd_data;
    logic              mem_rd_valid, err_clr;
    logic              stall, mem_rd_req, rf_wr_en_a, rf_wr_en_b, mem_err, ctrl_err;
    logic [3:0]        rf_wr_addr_a, rf_wr_addr_b;
    logic [DATA_W-1:0] rf_wr_data_a, rf_wr_data_b;
    logic [15:0]       retire_count;

    writeback_stage #(.DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read_in(mem_read_in),
        .reg_wr_en_1_in(reg_wr_en_1_in), .reg_wr_en_2_in(reg_wr_en_2_in),
        .buff_ctrl_in(buff_ctrl_in), .reg_wr_sel_in(reg_wr_sel_in),
        .alu_result(alu_result), .alu_result_hi(alu_result_hi), .imm_data(imm_data),
        .pc_plus1(pc_plus1), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .err_clr(err_clr), .stall(stall), .mem_rd_req(mem_rd_req),
        .rf_wr_en_a(rf_wr_en_a), .rf_wr_addr_a(rf_wr_addr_a), .rf_wr_data_a(rf_wr_data_a),
        .rf_wr_en_b(rf_wr_en_b), .rf_wr_addr_b(rf_wr_addr_b), .rf_wr_data_b(rf_wr_data_b),
        .mem_err(mem_err), .ctrl_err(ctrl_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit do_chk  = 1'b1;

    // Reference model: one outstanding load at most, tracked as a pending record
    bit          busy;
    int          waited;
    bit          p_en1, p_en2;
    int          p_sel, p_hi;
    bit          e_stall, e_req, e_wa, e_wb, e_merr, e_cerr;
    int          e_addr_a, e_data_a, e_addr_b, e_data_b, e_ret;

    task automatic model_reset();
        busy = 0; waited = 0; p_en1 = 0; p_en2 = 0; p_sel = 0; p_hi = 0;
        e_stall = 0; e_req = 0; e_wa = 0; e_wb = 0; e_merr = 0; e_cerr = 0;
        e_addr_a = 0; e_data_a = 0; e_addr_b = 0; e_data_b = 0; e_ret = 0;
    endtask

    task automatic model_step();
        bit mset = 0;
        bit cset = 0;
        e_wa = 0;
        e_wb = 0;
        if (!busy) begin
            if (in_valid) begin
                if (mem_read_in || buff_ctrl_in == 3'd1) begin
                    busy = 1; waited = 0;
                    p_en1 = reg_wr_en_1_in; p_en2 = reg_wr_en_2_in;
                    p_sel = int'(reg_wr_sel_in); p_hi = int'(alu_result_hi);
                    e_stall = 1; e_req = 1;
                end else begin
                    bit reserved = (int'(buff_ctrl_in) >= 5);
                    int val;
                    case (int'(buff_ctrl_in))
                        2:       val = int'(imm_data);
                        3:       val = int'(pc_plus1);
                        4:       val = int'(alu_result_hi);
                        default: val = int'(alu_result);
                    endcase
                    e_wa = reg_wr_en_1_in && !reserved;
                    e_wb = reg_wr_en_2_in && !reserved;
                    e_addr_a = int'(reg_wr_sel_in);
                    e_data_a = val;
                    e_addr_b = int'(reg_wr_sel_in) ^ 1;
                    e_data_b = int'(alu_result_hi);
                    e_ret = (e_ret + 1) % 65536;
                    cset = reserved;
                end
            end
        end else begin
            waited = waited + 1;
            if (mem_rd_valid) begin
                e_wa = p_en1; e_wb = p_en2;
                e_addr_a = p_sel; e_data_a = int'(mem_rd_data);
                e_addr_b = p_sel ^ 1; e_data_b = p_hi;
                e_ret = (e_ret + 1) % 65536;
                busy = 0; e_stall = 0; e_req = 0;
            end else if (waited == MEM_TIMEOUT) begin
                mset = 1;
                busy = 0; e_stall = 0; e_req = 0;
            end
        end
        e_merr = mset ? 1'b1 : (err_clr ? 1'b0 : e_merr);
        e_cerr = cset ? 1'b1 : (err_clr ? 1'b0 : e_cerr);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_rd_req", 32'(mem_rd_req), 32'(e_req));
        chk("wr_en_a", 32'(rf_wr_en_a), 32'(e_wa));
        chk("wr_en_b", 32'(rf_wr_en_b), 32'(e_wb));
        chk("mem_err", 32'(mem_err), 32'(e_merr));
        chk("ctrl_err", 32'(ctrl_err), 32'(e_cerr));
        chk("retire_count", 32'(retire_count), 32'(e_ret));
        if (e_wa) begin
            chk("wr_addr_a", 32'(rf_wr_addr_a), 32'(e_addr_a));
            chk("wr_data_a", 32'(rf_wr_data_a), 32'(e_data_a));
        end
        if (e_wb) begin
            chk("wr_addr_b", 32'(rf_wr_addr_b), 32'(e_addr_b));
            chk("wr_data_b", 32'(rf_wr_data_b), 32'(e_data_b));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic drive(input logic v, input logic mr, input logic e1, input logic e2,
                         input logic [2:0] bc, input logic [3:0] sel,
                         input logic [15:0] alu, input logic [15:0] hi);
        in_valid = v; mem_read_in = mr; reg_wr_en_1_in = e1; reg_wr_en_2_in = e2;
        buff_ctrl_in = bc; reg_wr_sel_in = sel; alu_result = alu; alu_result_hi = hi;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
        imm_data = 16'h0; pc_plus1 = 16'h0; mem_rd_valid = 0; mem_rd_data = 16'h0; err_clr = 0;
        model_reset();
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_wr_a", 32'(rf_wr_en_a), 32'd0);
        chk("rst_retire", 32'(retire_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU op
        drive(1, 0, 1, 1, 3'd0, 4'd4, 16'h1234, 16'hABCD);
        tick();
        chk("alu_addr_a", 32'(rf_wr_addr_a), 32'd4);
        chk("alu_data_a", 32'(rf_wr_data_a), 32'h1234);
        chk("alu_addr_b", 32'(rf_wr_addr_b), 32'd5);
        chk("alu_data_b", 32'(rf_wr_data_b), 32'hABCD);
        chk("alu_retire", 32'(retire_count), 32'd1);

        // Memory load answered on the third waiting cycle, then a back-to-back ALU op
        drive(1, 1, 1, 0, 3'd0, 4'd7, 16'h0, 16'h5555);
        tick();
        drive(0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("load_stall", 32'(stall), 32'd1);
            chk("load_req", 32'(mem_rd_req), 32'd1);
        end
        mem_rd_valid = 1; mem_rd_data = 16'hBEEF;
        drive(1, 0, 1, 0, 3'd0, 4'd2, 16'h0222, 16'h0);
        tick();
        chk("load_data", 32'(rf_wr_data_a), 32'hBEEF);
        chk("load_addr", 32'(rf_wr_addr_a), 32'd7);
        chk("load_stall_drop", 32'(stall), 32'd0);
        mem_rd_valid = 0;
        tick();
        chk("b2b_data", 32'(rf_wr_data_a), 32'h0222);
        chk("b2b_retire", 32'(retire_count), 32'd3);

        // Reserved source
        drive(1, 0, 1, 1, 3'd6, 4'd3, 16'h1111, 16'h2222);
        tick();
        chk("rsv_wr_a", 32'(rf_wr_en_a), 32'd0);
        chk("rsv_ctrl_err", 32'(ctrl_err), 32'd1);
        chk("rsv_retire", 32'(retire_count), 32'd4);

        // Timeout, then clear both sticky flags
        drive(1, 1, 1, 1, 3'd0, 4'd9, 16'h0, 16'h0);
        tick();
        drive(0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            tick();
            chk("to_stall", 32'(stall), 32'd1);
        end
        tick();
        chk("to_mem_err", 32'(mem_err), 32'd1);
        chk("to_stall_drop", 32'(stall), 32'd0);
        chk("to_no_write", 32'(rf_wr_en_a), 32'd0);
        chk("to_retire", 32'(retire_count), 32'd4);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_mem_err", 32'(mem_err), 32'd0);
        chk("clr_ctrl_err", 32'(ctrl_err), 32'd0);

        // Randomized traffic; low valid rate later to provoke timeouts
        for (int i = 0; i < 700; i++) begin
            int vpct = (i < 350) ? 40 : 4;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom));
            imm_data     = 16'($urandom);
            pc_plus1     = 16'($urandom);
            mem_rd_data  = 16'($urandom);
            mem_rd_valid = ($urandom_range(0, 99) < vpct);
            err_clr      = ($urandom_range(0, 9) == 0);
            tick();
        end
        mem_rd_valid = 0; err_clr = 0;

        // Reset in the middle of a wait
        drive(1, 1, 1, 1, 3'd0, 4'd2, 16'h0, 16'h0);
        while (busy) begin
            drive(0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
            mem_rd_valid = 1;
            tick();
            mem_rd_valid = 0;
        end
        drive(1, 1, 1, 1, 3'd0, 4'd2, 16'h0, 16'h0);
        tick();
        drive(0, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
        tick();
        tick();
        chk("mid_wait_stall", 32'(stall), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_req", 32'(mem_rd_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_wr_a", 32'(rf_wr_en_a), 32'd0);
        chk("arst_wr_b", 32'(rf_wr_en_b), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_rd_valid = 1; mem_rd_data = 16'hDEAD;
        tick();
        mem_rd_valid = 0;
        chk("late_valid_no_wr", 32'(rf_wr_en_a), 32'd0);
        chk("late_valid_retire", 32'(retire_count), 32'd0);

        // Retire counter wrap
        do_chk = 1'b0;
        drive(1, 0, 0, 0, 3'd0, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < 65535; i++) tick();
        do_chk = 1'b1;
        chk("wrap_pre", 32'(retire_count), 32'hFFFF);
        tick();
        chk("wrap_zero", 32'(retire_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
